// File: rtl/fsk16_symbol_mapper.sv
// 16FSK symbol mapper: packs scrambled bits into 4-bit symbols, prepends an
// alternating 0x0/0xF preamble and emits one FCW per symbol. Define FSK16_GRAY_MAP_EN to Gray-code data nibbles.
module fsk16_symbol_mapper #(
  parameter int                FCW_W      = 24,
  parameter logic [FCW_W-1:0]  F_BASE     = 24'h100000,
  parameter logic [FCW_W-1:0]  F_STEP     = 24'h004000,
  parameter int                PRE_LEN    = 8,
  parameter int                FRAME_SYMS = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_start,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic             bit_ready,
  output logic [3:0]       sym_idx,
  output logic             sym_valid,
  output logic [FCW_W-1:0] fcw,
  output logic             tx_en,
  output logic             frame_done
);

  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA} state_t;

  localparam logic [10:0] PRE_LAST  = 11'(PRE_LEN - 1);
  localparam logic [10:0] FRAME_END = 11'(FRAME_SYMS);

  state_t      state, next_state;
  logic [1:0]  pre_tick;
  logic [10:0] sym_cnt;
  logic [1:0]  bit_cnt;
  logic [3:0]  shift_reg;
  logic        sym_pend;
  logic        last_sym;
  logic        bit_accept;
  logic [3:0]  data_idx;
  logic [3:0]  pre_idx;

  function automatic logic [FCW_W-1:0] tone_fcw(input logic [3:0] idx);
    return F_BASE + FCW_W'(idx) * F_STEP;
  endfunction

  assign bit_ready  = (state == DATA);
  assign bit_accept = bit_ready & bit_valid;
  assign pre_idx    = sym_cnt[0] ? 4'hF : 4'h0;

`ifdef FSK16_GRAY_MAP_EN
  assign data_idx = shift_reg ^ (shift_reg >> 1);
`else
  assign data_idx = shift_reg;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (frame_start) next_state = PREAMBLE;
      PREAMBLE: if (pre_tick == 2'd3 && sym_cnt == PRE_LAST) next_state = DATA;
      DATA:     if (sym_pend && sym_cnt == FRAME_END) next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // A completed nibble is flagged and presented one edge later; the flag also
  // lets the last symbol's strobe coincide with leaving DATA.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_tick   <= '0;
      sym_cnt    <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      sym_pend   <= 1'b0;
      last_sym   <= 1'b0;
      sym_idx    <= '0;
      sym_valid  <= 1'b0;
      fcw        <= '0;
      tx_en      <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      sym_valid  <= 1'b0;
      frame_done <= last_sym;
      last_sym   <= 1'b0;
      if (last_sym) tx_en <= 1'b0;
      case (state)
        IDLE: begin
          if (frame_start) begin
            tx_en    <= 1'b1;
            pre_tick <= '0;
            sym_cnt  <= '0;
            bit_cnt  <= '0;
            sym_pend <= 1'b0;
          end
        end
        PREAMBLE: begin
          pre_tick <= pre_tick + 2'd1;
          if (pre_tick == 2'd3) begin
            sym_valid <= 1'b1;
            sym_idx   <= pre_idx;
            fcw       <= tone_fcw(pre_idx);
            sym_cnt   <= (sym_cnt == PRE_LAST) ? '0 : sym_cnt + 11'd1;
          end
        end
        DATA: begin
          if (sym_pend) begin
            sym_pend  <= 1'b0;
            sym_valid <= 1'b1;
            sym_idx   <= data_idx;
            fcw       <= tone_fcw(data_idx);
            last_sym  <= (sym_cnt == FRAME_END);
          end
          if (bit_accept) begin
            shift_reg <= {shift_reg[2:0], bit_in};
            bit_cnt   <= bit_cnt + 2'd1;
            if (bit_cnt == 2'd3) begin
              sym_pend <= 1'b1;
              sym_cnt  <= sym_cnt + 11'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fsk16_symbol_mapper.sv
// Bench for fsk16_symbol_mapper: directed frames with literal expectations, then
// randomized bits/frame_start/reset checked every cycle against a timeline model.
module tb_fsk16_symbol_mapper;

  localparam int PL = 8;
  localparam int FS = 4;

`ifdef FSK16_GRAY_MAP_EN
  localparam logic [3:0]  EXP_1011 = 4'hE;
  localparam logic [23:0] FCW_1011 = 24'h138000;
  localparam logic [3:0]  EXP_0110 = 4'h5;
  localparam logic [23:0] FCW_0110 = 24'h114000;
`else
  localparam logic [3:0]  EXP_1011 = 4'hB;
  localparam logic [23:0] FCW_1011 = 24'h12C000;
  localparam logic [3:0]  EXP_0110 = 4'h6;
  localparam logic [23:0] FCW_0110 = 24'h118000;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_start = 1'b0;
  logic        bit_in = 1'b0;
  logic        bit_valid = 1'b0;
  logic        bit_ready;
  logic [3:0]  sym_idx;
  logic        sym_valid;
  logic [23:0] fcw;
  logic        tx_en;
  logic        frame_done;

  int checks = 0;
  int failures = 0;

  fsk16_symbol_mapper #(
    .FCW_W(24), .F_BASE(24'h100000), .F_STEP(24'h004000),
    .PRE_LEN(PL), .FRAME_SYMS(FS)
  ) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .bit_in(bit_in),
    .bit_valid(bit_valid), .bit_ready(bit_ready), .sym_idx(sym_idx),
    .sym_valid(sym_valid), .fcw(fcw), .tx_en(tx_en), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] mapNibble(input logic [3:0] b);
`ifdef FSK16_GRAY_MAP_EN
    return b ^ {1'b0, b[3:1]};
`else
    return b;
`endif
  endfunction

  function automatic logic [23:0] fcwOf(input logic [3:0] idx);
    int v;
    v = 'h100000 + int'(idx) * 'h4000;
    return v[23:0];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic fs, input logic bv, input logic bi);
    @(negedge clk);
    frame_start = fs;
    bit_valid   = bv;
    bit_in      = bi;
  endtask

  // Timeline model: events are scheduled by edge number relative to the frame start
  // and the edge that completed each nibble.
  int          cyc = 0, start_cyc = 0, sym_cyc = -1, done_cyc = -1;
  int          nbits = 0, nsyms = 0, t = 0, k = 0;
  bit          in_pre = 0, in_data = 0, m_accept = 0, m_idle = 0;
  logic [3:0]  nib = '0, pending = '0;
  logic        e_bit_ready = 0, e_sym_valid = 0, e_tx_en = 0, e_frame_done = 0;
  logic [3:0]  e_sym_idx = '0;
  logic [23:0] e_fcw = '0;

  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      in_pre = 0; in_data = 0; nbits = 0; nsyms = 0; sym_cyc = -1; done_cyc = -1;
      e_bit_ready = 0; e_sym_valid = 0; e_tx_en = 0; e_frame_done = 0;
      e_sym_idx = '0; e_fcw = '0;
    end else begin
      cyc++;
      m_accept = e_bit_ready && bit_valid && (nbits < 4 * FS);
      m_idle   = !in_pre && !in_data;
      e_sym_valid = 0;
      e_frame_done = 0;
      if (cyc == done_cyc) begin
        e_frame_done = 1;
        e_tx_en = 0;
      end
      if (cyc == sym_cyc) begin
        e_sym_valid = 1;
        e_sym_idx = mapNibble(pending);
        e_fcw = fcwOf(e_sym_idx);
        if (nsyms == FS) begin
          e_bit_ready = 0;
          in_data = 0;
          done_cyc = cyc + 1;
        end
      end
      if (in_pre) begin
        t = cyc - start_cyc;
        if (t % 4 == 0) begin
          k = t / 4;
          e_sym_valid = 1;
          e_sym_idx = (k % 2 == 1) ? 4'h0 : 4'hF;
          e_fcw = fcwOf(e_sym_idx);
          if (k == PL) begin
            in_pre = 0;
            in_data = 1;
            e_bit_ready = 1;
          end
        end
      end
      if (m_accept) begin
        nib = {nib[2:0], bit_in};
        nbits++;
        if (nbits % 4 == 0) begin
          pending = nib;
          nsyms++;
          sym_cyc = cyc + 1;
        end
      end
      if (m_idle && frame_start) begin
        in_pre = 1;
        start_cyc = cyc;
        e_tx_en = 1;
        nbits = 0;
        nsyms = 0;
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rst === 1'b1) begin
      checkOutput("sym_valid", sym_valid, e_sym_valid);
      checkOutput("sym_idx", sym_idx, e_sym_idx);
      checkOutput("fcw", fcw, e_fcw);
      checkOutput("tx_en", tx_en, e_tx_en);
      checkOutput("bit_ready", bit_ready, e_bit_ready);
      checkOutput("frame_done", frame_done, e_frame_done);
    end
  end

  initial begin
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_sym_valid", sym_valid, 0);
    checkOutput("rst_fcw", fcw, 0);
    checkOutput("rst_tx_en", tx_en, 0);
    checkOutput("rst_bit_ready", bit_ready, 0);
    rst = 1'b1;
    repeat (100) applyStimulus(0, 0, 0);

    // Frame 1: preamble timing, dropped bits, mapping, gaps, frame_done.
    applyStimulus(1, 0, 0);
    @(posedge clk); #1;
    checkOutput("start_tx_en", tx_en, 1);
    repeat (4) applyStimulus(0, 0, 0);
    @(posedge clk); #1;
    checkOutput("pre1_valid", sym_valid, 1);
    checkOutput("pre1_idx", sym_idx, 4'h0);
    checkOutput("pre1_fcw", fcw, 24'h100000);
    applyStimulus(1, 0, 0);
    repeat (3) applyStimulus(0, 0, 0);
    @(posedge clk); #1;
    checkOutput("pre2_idx", sym_idx, 4'hF);
    checkOutput("pre2_fcw", fcw, 24'h13C000);
    repeat (24) applyStimulus(0, 1, 1);
    @(posedge clk); #1;
    checkOutput("pre8_valid", sym_valid, 1);
    checkOutput("pre8_idx", sym_idx, 4'hF);
    checkOutput("data_ready", bit_ready, 1);
    applyStimulus(0, 1, 1);
    applyStimulus(0, 1, 0);
    applyStimulus(0, 1, 1);
    applyStimulus(0, 1, 1);
    applyStimulus(0, 0, 0);
    @(posedge clk); #1;
    checkOutput("n1011_valid", sym_valid, 1);
    checkOutput("n1011_idx", sym_idx, EXP_1011);
    checkOutput("n1011_fcw", fcw, FCW_1011);
    applyStimulus(0, 1, 1);
    applyStimulus(1, 0, 0);
    applyStimulus(0, 0, 1);
    applyStimulus(0, 1, 0);
    applyStimulus(0, 1, 1);
    applyStimulus(0, 0, 0);
    applyStimulus(0, 1, 1);
    applyStimulus(0, 0, 0);
    @(posedge clk); #1;
    checkOutput("gap_valid", sym_valid, 1);
    checkOutput("gap_idx", sym_idx, EXP_1011);
    repeat (8) applyStimulus(0, 1, 1'($urandom));
    applyStimulus(0, 0, 0);
    applyStimulus(0, 0, 0);
    @(posedge clk); #1;
    checkOutput("done_pulse", frame_done, 1);
    checkOutput("done_tx_en", tx_en, 0);
    checkOutput("done_ready", bit_ready, 0);

    // Restart from IDLE, then abort mid-nibble with reset.
    applyStimulus(0, 1, 1);
    applyStimulus(0, 1, 1);
    applyStimulus(1, 0, 0);
    @(posedge clk); #1;
    checkOutput("restart_tx_en", tx_en, 1);
    repeat (4) applyStimulus(0, 0, 0);
    @(posedge clk); #1;
    checkOutput("restart_pre_valid", sym_valid, 1);
    repeat (28) applyStimulus(0, 0, 0);
    applyStimulus(0, 1, 1);
    applyStimulus(0, 1, 0);
    applyStimulus(0, 0, 0);
    #2 rst = 1'b0;
    #1;
    checkOutput("abort_sym_idx", sym_idx, 0);
    checkOutput("abort_fcw", fcw, 0);
    checkOutput("abort_tx_en", tx_en, 0);
    checkOutput("abort_ready", bit_ready, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    applyStimulus(1, 0, 0);
    repeat (32) applyStimulus(0, 0, 0);
    applyStimulus(0, 1, 0);
    applyStimulus(0, 1, 1);
    applyStimulus(0, 1, 1);
    applyStimulus(0, 1, 0);
    applyStimulus(0, 0, 0);
    @(posedge clk); #1;
    checkOutput("fresh_valid", sym_valid, 1);
    checkOutput("fresh_idx", sym_idx, EXP_0110);
    checkOutput("fresh_fcw", fcw, FCW_0110);

    // Randomized traffic with occasional frame_start pulses and resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
      end
      applyStimulus($urandom_range(0, 15) == 0, $urandom_range(0, 99) < 70, 1'($urandom));
    end
    applyStimulus(0, 0, 0);
    @(posedge clk); #2;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
